// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first, one bit per cycle
// Optional SERIAL_SUB_SAT_EN: saturate diff on signed overflow.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, res;
  logic             br, a_msb, b_msb;
  logic [CW-1:0]    cnt;

  logic             d, br_next, ovf_next;
  logic [WIDTH-1:0] res_next, diff_next;

  always_comb begin
    d         = sa[0] ^ sb[0] ^ br;
    br_next   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_next  = {d, res[WIDTH-1:1]};
    // Only possible when operand signs differ and the result sign flips away from a.
    ovf_next  = (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
    diff_next = res_next;
`ifdef SERIAL_SUB_SAT_EN
    if (ovf_next)
      diff_next = {a_msb, {(WIDTH-1){~a_msb}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_next;
          br  <= br_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff       <= diff_next;
            borrow_out <= br_next;
            ovf        <= ovf_next;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
